tick_period_meter: RTL and testbench

- Receive-side checker for single-cycle tick streams produced by the team's mclk frequency dividers.
- Measures the interval between rising edges of tick_in in mclk cycles and reports each measured period.
- Declares lock after a run of in-tolerance periods; flags timeouts and mismatches.
- Sits beside the divider or ring-counter logic as a built-in rate monitor; tick_in is synchronous to mclk.

---
 rtl/tpm_pkg.sv | 31 +++
 rtl/tpm_edge_det.sv | 21 ++
 rtl/tick_period_meter.sv | 137 +++++++++++++
 tb/tb_tick_period_meter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpm_pkg.sv
// Shared definitions for the tick period meter: state encoding, default
// parameter values and the period tolerance check.
package tpm_pkg;

  // Measurement state encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t MEASURE = 2'd1;
  localparam state_t LOCKED  = 2'd2;

  // Default configuration
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_NOM_PERIOD = 10;
  localparam int DEF_TOL        = 0;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_TIMEOUT    = 1023;

  // True when cnt lies inside [nom-tol, nom+tol]. Bounds are computed one bit
  // wider than the operands and the lower bound clamps at zero, so a tolerance
  // larger than the nominal period cannot wrap around.
  function automatic logic period_match(input logic [31:0] cnt,
                                        input logic [31:0] nom,
                                        input logic [31:0] tol);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = (tol > nom) ? 33'd0 : ({1'b0, nom} - {1'b0, tol});
    hi = {1'b0, nom} + {1'b0, tol};
    return ({1'b0, cnt} >= lo) && ({1'b0, cnt} <= hi);
  endfunction

endpackage

// File: rtl/tpm_edge_det.sv
// Registered rising-edge detector. The history flop resets low, so an input
// already high on the first sample after reset is reported as an edge, and a
// level held high yields exactly one edge.
module tpm_edge_det (
  input  logic mclk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Remember the previous sample of din
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/tick_period_meter.sv
// Tick period meter: measures the mclk-cycle interval between rising edges of
// tick_in, reports each period, declares lock after LOCK_COUNT consecutive
// in-tolerance periods and strobes on mismatch (while locked) or timeout.
// Optional build macro TICK_PERIOD_METER_MINMAX_EN adds period_min/period_max
// tracking outputs.
module tick_period_meter
  import tpm_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int NOM_PERIOD = DEF_NOM_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout_err
`ifdef TICK_PERIOD_METER_MINMAX_EN
  ,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_V    = 4'(LOCK_COUNT);

  logic             rise;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       match_cnt;
  logic [3:0]       match_next;
  logic             is_match;
  logic             timeout_hit;
  logic             capture;

  tpm_edge_det u_edge_det (
    .mclk (mclk),
    .rst  (rst),
    .din  (tick_in),
    .rise (rise)
  );

  assign is_match    = period_match(32'(cnt), 32'(NOM_PERIOD), 32'(TOL));
  assign match_next  = match_cnt + 4'd1;
  assign capture     = rise && (state != IDLE);
  // An edge arriving on the timeout cycle takes priority over the timeout
  assign timeout_hit = (state != IDLE) && !rise && (cnt == TIMEOUT_V);

  // Measurement state machine, interval counter, period capture and strobes
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      mismatch     <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) begin
            state     <= MEASURE;
            cnt       <= CNT_ONE;
            match_cnt <= '0;
          end
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            cnt          <= CNT_ONE;
            period       <= cnt;
            period_valid <= 1'b1;
            if (state == MEASURE) begin
              if (is_match) begin
                match_cnt <= match_next;
                if (match_next == LOCK_V) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end else if (!is_match) begin
              mismatch  <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              state     <= MEASURE;
            end
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            locked      <= 1'b0;
            match_cnt   <= '0;
            cnt         <= '0;
            state       <= IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef TICK_PERIOD_METER_MINMAX_EN
  // Running extremes of captured periods; the reset values make the first
  // capture load both, and a timeout starts a fresh window
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      period_min <= '1;
      period_max <= '0;
    end else if (timeout_hit) begin
      period_min <= '1;
      period_max <= '0;
    end else if (capture) begin
      if (cnt < period_min) period_min <= cnt;
      if (cnt > period_max) period_max <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Testbench for tick_period_meter. Two instances share clock and reset:
// dut_a (TOL=0) and dut_b (TOL=1), each with its own tick stream. Stimulus
// pushes the expected strobe events into per-instance queues; a monitor pops
// and compares whenever an instance raises period_valid, mismatch or
// timeout_err. Build with TICK_PERIOD_METER_MINMAX_EN to also check min/max.
module tb_tick_period_meter;

  localparam int CW = 16;

  logic mclk = 1'b0;
  logic rst = 1'b1;
  logic tick_a = 1'b0;
  logic tick_b = 1'b0;

  logic [CW-1:0] period_a, period_b;
  logic pv_a, lk_a, mm_a, to_a;
  logic pv_b, lk_b, mm_b, to_b;
`ifdef TICK_PERIOD_METER_MINMAX_EN
  logic [CW-1:0] min_a, max_a, min_b, max_b;
`endif

  typedef struct {
    int          cyc;
    logic [15:0] period;
    logic        pv;
    logic        mm;
    logic        to;
    logic        lk;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  ev_t mon_e;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;

  tick_period_meter #(.CNT_W(CW), .NOM_PERIOD(10), .TOL(0), .LOCK_COUNT(4), .TIMEOUT(64)) dut_a (
    .mclk(mclk), .rst(rst), .tick_in(tick_a),
    .period(period_a), .period_valid(pv_a), .locked(lk_a),
    .mismatch(mm_a), .timeout_err(to_a)
`ifdef TICK_PERIOD_METER_MINMAX_EN
    , .period_min(min_a), .period_max(max_a)
`endif
  );

  tick_period_meter #(.CNT_W(CW), .NOM_PERIOD(10), .TOL(1), .LOCK_COUNT(4), .TIMEOUT(64)) dut_b (
    .mclk(mclk), .rst(rst), .tick_in(tick_b),
    .period(period_b), .period_valid(pv_b), .locked(lk_b),
    .mismatch(mm_b), .timeout_err(to_b)
`ifdef TICK_PERIOD_METER_MINMAX_EN
    , .period_min(min_b), .period_max(max_b)
`endif
  );

  // 10 ns mclk
  always #5 mclk = ~mclk;

  // Drive one cycle of tick values; returns 1 ns after the sampling edge
  task automatic step(input logic a, input logic b);
    tick_a = a;
    tick_b = b;
    @(posedge mclk);
    cyc++;
    #1;
  endtask

  // Queue an event expected to be registered on the next clock edge
  task automatic expect_ev(input bit sel_b, input logic [15:0] p, input logic pv,
                           input logic mm, input logic to, input logic lk);
    ev_t e;
    e.cyc = cyc + 1;
    e.period = p;
    e.pv = pv;
    e.mm = mm;
    e.to = to;
    e.lk = lk;
    if (sel_b) q_b.push_back(e);
    else       q_a.push_back(e);
  endtask

  // Single-cycle tick 'gap' cycles after the previous edge, with its expected report
  task automatic edge_after(input bit sel_b, input int gap, input logic [15:0] p,
                            input logic mm, input logic lk);
    repeat (gap - 1) step(1'b0, 1'b0);
    expect_ev(sel_b, p, 1'b1, mm, 1'b0, lk);
    if (sel_b) step(1'b0, 1'b1);
    else       step(1'b1, 1'b0);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_ev(input string name, input ev_t e, input logic [15:0] p,
                          input logic pv, input logic mm, input logic to, input logic lk);
    checks++;
    if (e.cyc != cyc || pv !== e.pv || mm !== e.mm || to !== e.to || lk !== e.lk ||
        (e.pv && p !== e.period)) begin
      errors++;
      $display("[TB] FAIL %s event: got cyc=%0d period=%0d pv=%b mm=%b to=%b lk=%b, expected cyc=%0d period=%0d pv=%b mm=%b to=%b lk=%b",
               name, cyc, p, pv, mm, to, lk, e.cyc, e.period, e.pv, e.mm, e.to, e.lk);
    end
  endtask

  // Scoreboard monitor: flag expected events that never appeared, then match
  // any strobe the instances present against the queue head
  always @(negedge mclk) begin
    if (!rst) begin
      while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
        mon_e = q_a.pop_front();
        checks++; errors++;
        $display("[TB] FAIL dut_a missing event: expected at cyc=%0d period=%0d, no strobe arrived", mon_e.cyc, mon_e.period);
      end
      while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
        mon_e = q_b.pop_front();
        checks++; errors++;
        $display("[TB] FAIL dut_b missing event: expected at cyc=%0d period=%0d, no strobe arrived", mon_e.cyc, mon_e.period);
      end
      if (pv_a || mm_a || to_a) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL dut_a spurious event: cyc=%0d period=%0d pv=%b mm=%b to=%b, expected none", cyc, period_a, pv_a, mm_a, to_a);
        end else begin
          mon_e = q_a.pop_front();
          check_ev("dut_a", mon_e, period_a, pv_a, mm_a, to_a, lk_a);
        end
      end
      if (pv_b || mm_b || to_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL dut_b spurious event: cyc=%0d period=%0d pv=%b mm=%b to=%b, expected none", cyc, period_b, pv_b, mm_b, to_b);
        end else begin
          mon_e = q_b.pop_front();
          check_ev("dut_b", mon_e, period_b, pv_b, mm_b, to_b, lk_b);
        end
      end
    end
  end

  initial begin
    // Reset state
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_val("reset period", 32'(period_a), 32'd0);
    check_val("reset period_valid", 32'(pv_a), 32'd0);
    check_val("reset locked", 32'(lk_a), 32'd0);
    check_val("reset mismatch", 32'(mm_a), 32'd0);
    check_val("reset timeout_err", 32'(to_a), 32'd0);
    check_val("reset locked b", 32'(lk_b), 32'd0);
`ifdef TICK_PERIOD_METER_MINMAX_EN
    check_val("reset period_min", 32'(min_a), 32'hFFFF);
    check_val("reset period_max", 32'(max_a), 32'h0);
`endif
    rst = 1'b0;
    step(1'b0, 1'b0);

    // Steady 10-cycle ticks: first edge silent, lock on the 5th edge
    step(1'b1, 1'b0);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b0);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b0);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b0);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b1);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b1);

    // One long period breaks lock, four good periods restore it
    edge_after(1'b0, 11, 16'd11, 1'b1, 1'b0);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b0);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b0);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b0);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b1);
    check_val("relocked", 32'(lk_a), 32'd1);
`ifdef TICK_PERIOD_METER_MINMAX_EN
    check_val("period_min after relock", 32'(min_a), 32'd10);
    check_val("period_max after relock", 32'(max_a), 32'd11);
`endif

    // Ticks stop: timeout strobe 64 cycles after the last edge
    repeat (63) step(1'b0, 1'b0);
    expect_ev(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_val("locked after timeout", 32'(lk_a), 32'd0);
`ifdef TICK_PERIOD_METER_MINMAX_EN
    check_val("period_min after timeout", 32'(min_a), 32'hFFFF);
    check_val("period_max after timeout", 32'(max_a), 32'h0);
`endif
    repeat (5) step(1'b0, 1'b0);

    // Level held high 5 cycles counts as one silent edge, then 10-cycle pulses
    repeat (5) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    expect_ev(1'b0, 16'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b0);

    // Asynchronous reset mid-measurement with cnt at 7
    repeat (6) step(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_val("mid-reset period", 32'(period_a), 32'd0);
    check_val("mid-reset period_valid", 32'(pv_a), 32'd0);
    check_val("mid-reset locked", 32'(lk_a), 32'd0);
    check_val("mid-reset mismatch", 32'(mm_a), 32'd0);
    check_val("mid-reset timeout_err", 32'(to_a), 32'd0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);

    // TOL=1 instance: 9 and 11 are in tolerance, 12 is not
    step(1'b0, 1'b1);
    edge_after(1'b1, 10, 16'd10, 1'b0, 1'b0);
    edge_after(1'b1,  9, 16'd9,  1'b0, 1'b0);
    edge_after(1'b1, 11, 16'd11, 1'b0, 1'b0);
    edge_after(1'b1, 10, 16'd10, 1'b0, 1'b1);
    edge_after(1'b1,  9, 16'd9,  1'b0, 1'b1);
    edge_after(1'b1, 11, 16'd11, 1'b0, 1'b1);
    edge_after(1'b1, 12, 16'd12, 1'b1, 1'b0);
`ifdef TICK_PERIOD_METER_MINMAX_EN
    check_val("period_min b", 32'(min_b), 32'd9);
    check_val("period_max b", 32'(max_b), 32'd12);
`endif

    // First edge after the mid-run reset is silent, the next reports 10
    step(1'b1, 1'b0);
    edge_after(1'b0, 10, 16'd10, 1'b0, 1'b0);

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_val("dut_a queue drained", 32'(q_a.size()), 32'd0);
    check_val("dut_b queue drained", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
